int_ctrl: RTL and testbench

Interrupt controller for the 5-stage RISC pipeline. It sits beside the decode-stage control FSM and owns the whole interrupt entry sequence:
- latch the external request;
- wait until the decode controller is not mid-sequence;
- freeze fetch and drain the pipeline;
- push PC high, PC low and flags through the memory-stage stack port;
- fetch the 32-bit handler vector from data memory and load it into the PC.

It then blocks further entries until the decode controller reports RETI completion.

---
 rtl/int_pkg.sv | 20 ++
 rtl/int_edge_latch.sv | 37 +++
 rtl/int_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_int_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared types and widths for the pipeline interrupt controller.
package int_pkg;

    localparam int unsigned STACK_W    = 16;
    localparam int unsigned FLAG_W_DEF = 3;
    localparam int unsigned PC_W_DEF   = 2 * STACK_W;

    typedef enum logic [3:0] {
        IDLE,
        DRAIN,
        PUSH_PCH,
        PUSH_PCL,
        PUSH_FLG,
        VEC_H,
        VEC_L,
        LOAD,
        SERVICE
    } int_state_t;

endpackage

// File: rtl/int_edge_latch.sv
// Rising-edge detector on irq feeding a sticky pending bit.
// A clear arriving with a new edge wins: that edge is absorbed by the entry under way.
module int_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic clr,
    output logic pending
);

    logic irq_q, irq_d;
    logic pending_q, pending_d;

    always_comb begin
        irq_d     = irq;
        pending_d = pending_q;
        if (irq && !irq_q) begin
            pending_d = 1'b1;
        end
        if (clr) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            irq_q     <= irq_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt entry sequencer: drain, push PC/flags, fetch vector, load PC,
// then hold off further entries until RETI completes.
module int_ctrl
    import int_pkg::*;
#(
    parameter int unsigned        PC_W         = PC_W_DEF,
    parameter int unsigned        FLAG_W       = FLAG_W_DEF,
    parameter int unsigned        DRAIN_CYCLES = 4,
    parameter logic [STACK_W-1:0] VEC_ADDR     = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               irq,
    input  logic               ctl_busy,
    input  logic               rti_done,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [FLAG_W-1:0]  flags_in,
    output logic               stall_fetch,
    output logic               push_valid,
    output logic [STACK_W-1:0] push_data,
    input  logic               push_ready,
    output logic               rd_req,
    output logic [STACK_W-1:0] rd_addr,
    input  logic               rd_valid,
    input  logic [STACK_W-1:0] rd_data,
    output logic               pc_load,
    output logic [PC_W-1:0]    pc_load_value,
    output logic               int_active
);

    localparam int unsigned        CNT_W       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [STACK_W-1:0] VEC_ADDR_LO = STACK_W'(VEC_ADDR + 16'd1);

    int_state_t         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [FLAG_W-1:0]  flg_q, flg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STACK_W-1:0] vec_hi_q, vec_hi_d;
    logic [STACK_W-1:0] vec_lo_q, vec_lo_d;

    logic               stall_fetch_q, stall_fetch_d;
    logic               push_valid_q, push_valid_d;
    logic [STACK_W-1:0] push_data_q, push_data_d;
    logic               rd_req_q, rd_req_d;
    logic [STACK_W-1:0] rd_addr_q, rd_addr_d;
    logic               pc_load_q, pc_load_d;
    logic [PC_W-1:0]    pc_load_value_q, pc_load_value_d;
    logic               int_active_q, int_active_d;

    logic pending;
    logic pend_clr_c;

    int_edge_latch u_edge (
        .clk     (clk),
        .reset   (reset),
        .irq     (irq),
        .clr     (pend_clr_c),
        .pending (pending)
    );

    // Next state, then outputs decoded from the next state so they register in step with it.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        flg_d           = flg_q;
        cnt_d           = cnt_q;
        vec_hi_d        = vec_hi_q;
        vec_lo_d        = vec_lo_q;
        pend_clr_c      = 1'b0;

        stall_fetch_d   = 1'b0;
        push_valid_d    = 1'b0;
        push_data_d     = '0;
        rd_req_d        = 1'b0;
        rd_addr_d       = '0;
        pc_load_d       = 1'b0;
        pc_load_value_d = '0;
        int_active_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending && !ctl_busy) begin
                    pc_d    = pc_in;
                    flg_d   = flags_in;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    pend_clr_c = 1'b1;
                    state_d    = PUSH_PCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PUSH_PCH: if (push_ready) state_d = PUSH_PCL;
            PUSH_PCL: if (push_ready) state_d = PUSH_FLG;
            PUSH_FLG: if (push_ready) state_d = VEC_H;
            VEC_H: begin
                if (rd_valid) begin
                    vec_hi_d = rd_data;
                    state_d  = VEC_L;
                end
            end
            VEC_L: begin
                if (rd_valid) begin
                    vec_lo_d = rd_data;
                    state_d  = LOAD;
                end
            end
            LOAD:    state_d = SERVICE;
            SERVICE: if (rti_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            DRAIN: stall_fetch_d = 1'b1;
            PUSH_PCH: begin
                stall_fetch_d = 1'b1;
                push_valid_d  = 1'b1;
                push_data_d   = pc_q[PC_W-1 -: STACK_W];
            end
            PUSH_PCL: begin
                stall_fetch_d = 1'b1;
                push_valid_d  = 1'b1;
                push_data_d   = pc_q[STACK_W-1:0];
            end
            PUSH_FLG: begin
                stall_fetch_d = 1'b1;
                push_valid_d  = 1'b1;
                push_data_d   = STACK_W'(flg_q);
            end
            VEC_H: begin
                stall_fetch_d = 1'b1;
                rd_req_d      = 1'b1;
                rd_addr_d     = VEC_ADDR;
            end
            VEC_L: begin
                stall_fetch_d = 1'b1;
                rd_req_d      = 1'b1;
                rd_addr_d     = VEC_ADDR_LO;
            end
            LOAD: begin
                stall_fetch_d   = 1'b1;
                pc_load_d       = 1'b1;
                pc_load_value_d = PC_W'({vec_hi_q, vec_lo_d});
            end
            SERVICE: int_active_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            pc_q            <= '0;
            flg_q           <= '0;
            cnt_q           <= '0;
            vec_hi_q        <= '0;
            vec_lo_q        <= '0;
            stall_fetch_q   <= 1'b0;
            push_valid_q    <= 1'b0;
            push_data_q     <= '0;
            rd_req_q        <= 1'b0;
            rd_addr_q       <= '0;
            pc_load_q       <= 1'b0;
            pc_load_value_q <= '0;
            int_active_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            flg_q           <= flg_d;
            cnt_q           <= cnt_d;
            vec_hi_q        <= vec_hi_d;
            vec_lo_q        <= vec_lo_d;
            stall_fetch_q   <= stall_fetch_d;
            push_valid_q    <= push_valid_d;
            push_data_q     <= push_data_d;
            rd_req_q        <= rd_req_d;
            rd_addr_q       <= rd_addr_d;
            pc_load_q       <= pc_load_d;
            pc_load_value_q <= pc_load_value_d;
            int_active_q    <= int_active_d;
        end
    end

    assign stall_fetch   = stall_fetch_q;
    assign push_valid    = push_valid_q;
    assign push_data     = push_data_q;
    assign rd_req        = rd_req_q;
    assign rd_addr       = rd_addr_q;
    assign pc_load       = pc_load_q;
    assign pc_load_value = pc_load_value_q;
    assign int_active    = int_active_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: entry latency, stack pushes, vector fetch, busy hold,
// backpressure, nesting block, async reset and edge merging.
module tb_int_ctrl;

    logic        clk;
    logic        reset;
    logic        irq;
    logic        ctl_busy;
    logic        rti_done;
    logic [31:0] pc_in;
    logic [2:0]  flags_in;
    logic        stall_fetch;
    logic        push_valid;
    logic [15:0] push_data;
    logic        push_ready;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        int_active;

    logic [15:0] vec_mem [2];
    logic [15:0] push_log [$];
    logic [15:0] rd_log [$];

    int n_tests = 0;
    int n_fail  = 0;

    assign rd_data = vec_mem[rd_addr[0]];

    int_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .irq           (irq),
        .ctl_busy      (ctl_busy),
        .rti_done      (rti_done),
        .pc_in         (pc_in),
        .flags_in      (flags_in),
        .stall_fetch   (stall_fetch),
        .push_valid    (push_valid),
        .push_data     (push_data),
        .push_ready    (push_ready),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .int_active    (int_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed handshake as the memory stage would see it.
    always @(posedge clk) begin
        if (reset && push_valid && push_ready) push_log.push_back(push_data);
        if (reset && rd_req && rd_valid) rd_log.push_back(rd_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle 1 is the cycle irq is raised; pat[k-1] is irq during cycle k.
    task automatic run_entry(input logic [31:0] pc, input logic [2:0] fl, input logic [7:0] pat,
                             input int pr_holds, input int rv_holds, output int lat);
        int cyc;
        int ph;
        int rh;
        ph  = 0;
        rh  = 0;
        lat = 0;
        push_log.delete();
        rd_log.delete();
        pc_in    = pc;
        flags_in = fl;
        irq      = pat[0];
        cyc      = 1;
        for (int i = 0; i < 60; i++) begin
            step();
            cyc++;
            irq        = (cyc <= 8) ? pat[3'(cyc - 1)] : 1'b0;
            push_ready = 1'b1;
            rd_valid   = 1'b1;
            if (push_valid && push_log.size() == 1) begin
                check("pcl_data_stable", 32'(push_data), 32'(pc[15:0]));
                if (ph < pr_holds) begin
                    push_ready = 1'b0;
                    ph++;
                end
            end
            if (rd_req && rd_log.size() == 0) begin
                check("vech_addr_stable", 32'(rd_addr), 32'h0);
                if (rh < rv_holds) begin
                    rd_valid = 1'b0;
                    rh++;
                end
            end
            if (pc_load) begin
                lat = cyc;
                break;
            end
        end
        irq        = 1'b0;
        push_ready = 1'b1;
        rd_valid   = 1'b1;
        if (lat == 0) check("entry_timeout", 32'(pc_load), 32'h1);
    endtask

    task automatic run_to_load(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            n++;
            if (pc_load) break;
        end
    endtask

    task automatic check_pushes(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2);
        check({tag, "_push_cnt"}, 32'(push_log.size()), 32'd3);
        if (push_log.size() >= 3) begin
            check({tag, "_push_pch"}, 32'(push_log[0]), 32'(w0));
            check({tag, "_push_pcl"}, 32'(push_log[1]), 32'(w1));
            check({tag, "_push_flg"}, 32'(push_log[2]), 32'(w2));
        end
    endtask

    task automatic do_rti(input string tag);
        rti_done = 1'b1;
        step();
        rti_done = 1'b0;
        check({tag, "_rti_inactive"}, 32'(int_active), 32'h0);
    endtask

    initial begin
        int lat;
        int n;
        int cnt;

        reset      = 1'b0;
        irq        = 1'b0;
        ctl_busy   = 1'b0;
        rti_done   = 1'b0;
        pc_in      = '0;
        flags_in   = '0;
        push_ready = 1'b1;
        rd_valid   = 1'b1;
        vec_mem[0] = 16'h0000;
        vec_mem[1] = 16'h0100;

        // Reset state
        step();
        step();
        check("rst_ctrl_outs", {27'd0, stall_fetch, push_valid, rd_req, pc_load, int_active}, 32'h0);
        check("rst_push_data", 32'(push_data), 32'h0);
        check("rst_rd_addr", 32'(rd_addr), 32'h0);
        check("rst_pc_load_value", pc_load_value, 32'h0);
        reset = 1'b1;
        step();

        // Basic entry
        run_entry(32'h0001_2345, 3'b101, 8'b0000_0001, 0, 0, lat);
        check("basic_latency", 32'(lat), 32'd12);
        check("basic_pc_load_value", pc_load_value, 32'h0000_0100);
        check("basic_stall_in_load", 32'(stall_fetch), 32'h1);
        check_pushes("basic", 16'h0001, 16'h2345, 16'h0005);
        check("basic_rd_cnt", 32'(rd_log.size()), 32'd2);
        if (rd_log.size() >= 2) begin
            check("basic_rd_hi_addr", 32'(rd_log[0]), 32'h0000);
            check("basic_rd_lo_addr", 32'(rd_log[1]), 32'h0001);
        end
        step();
        check("basic_load_one_cycle", 32'(pc_load), 32'h0);
        check("basic_service", {30'd0, int_active, stall_fetch}, 32'h2);
        do_rti("basic");

        // Busy hold
        push_log.delete();
        pc_in    = 32'h1234_5678;
        flags_in = 3'b011;
        ctl_busy = 1'b1;
        irq      = 1'b1;
        cnt      = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            irq = 1'b0;
            if (stall_fetch) cnt++;
        end
        check("busy_no_stall", 32'(cnt), 32'd0);
        ctl_busy = 1'b0;
        step();
        check("busy_stall_after_fall", 32'(stall_fetch), 32'h1);
        run_to_load(n);
        check("busy_drain_to_load", 32'(n), 32'd9);
        check_pushes("busy", 16'h1234, 16'h5678, 16'h0003);
        step();
        do_rti("busy");

        // Backpressure: 3 refused pushes on PC low, 2-cycle late vector-high read
        vec_mem[0] = 16'h8000;
        vec_mem[1] = 16'h0040;
        run_entry(32'hDEAD_BEEF, 3'b010, 8'b0000_0001, 3, 2, lat);
        check("bp_latency", 32'(lat), 32'd17);
        check("bp_pc_load_value", pc_load_value, 32'h8000_0040);
        check_pushes("bp", 16'hDEAD, 16'hBEEF, 16'h0002);
        vec_mem[0] = 16'h0000;
        vec_mem[1] = 16'h0100;
        step();
        do_rti("bp");

        // Nesting block, re-entry one cycle after rti_done
        run_entry(32'h0000_0010, 3'b001, 8'b0000_0001, 0, 0, lat);
        check("nest_first_latency", 32'(lat), 32'd12);
        step();
        irq = 1'b1;
        step();
        irq = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (stall_fetch) cnt++;
        end
        check("nest_no_stall", 32'(cnt), 32'd0);
        check("nest_still_active", 32'(int_active), 32'h1);
        rti_done = 1'b1;
        step();
        rti_done = 1'b0;
        check("nest_idle_after_rti", {30'd0, int_active, stall_fetch}, 32'h0);
        step();
        check("nest_reentry_stall", 32'(stall_fetch), 32'h1);
        run_to_load(n);
        check("nest_reentry_to_load", 32'(n), 32'd9);
        step();
        do_rti("nest");

        // Edge arriving in the same cycle as rti_done
        run_entry(32'h0000_0020, 3'b000, 8'b0000_0001, 0, 0, lat);
        step();
        irq      = 1'b1;
        rti_done = 1'b1;
        step();
        irq      = 1'b0;
        rti_done = 1'b0;
        check("same_cyc_idle", 32'(int_active), 32'h0);
        step();
        check("same_cyc_reentry_stall", 32'(stall_fetch), 32'h1);
        run_to_load(n);
        check("same_cyc_to_load", 32'(n), 32'd9);
        step();
        do_rti("same_cyc");

        // Edge merge: pulses in cycles 1, 3 and 5 give a single entry
        run_entry(32'h0000_4444, 3'b111, 8'b0001_0101, 0, 0, lat);
        check("merge_latency", 32'(lat), 32'd12);
        check_pushes("merge", 16'h0000, 16'h4444, 16'h0007);
        step();
        do_rti("merge");
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (stall_fetch || push_valid) cnt++;
        end
        check("merge_single_entry", 32'(cnt), 32'd0);

        // Reset in PUSH_FLG
        push_log.delete();
        pc_in    = 32'h0000_5555;
        flags_in = 3'b100;
        irq      = 1'b1;
        cnt      = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            irq = 1'b0;
            if (push_valid && push_log.size() == 2) begin
                cnt = 1;
                break;
            end
        end
        check("rstmid_reached_flg", 32'(cnt), 32'h1);
        reset = 1'b0;
        #1;
        check("rstmid_outs_zero", {27'd0, stall_fetch, push_valid, rd_req, pc_load, int_active}, 32'h0);
        check("rstmid_push_data_zero", 32'(push_data), 32'h0);
        step();
        step();
        reset = 1'b1;
        cnt   = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (stall_fetch || push_valid) cnt++;
        end
        check("rstmid_no_resume", 32'(cnt), 32'd0);
        check("rstmid_push_cnt", 32'(push_log.size()), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
